// File: rtl/branch_pkg.sv
// Shared types and default sizes for the branch/jump control stage.
// Holds the branch opcode encoding and default width/depth constants.
package branch_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        BZ    = 3'd1,
        BNZ   = 3'd2,
        BC    = 3'd3,
        JMP   = 3'd4,
        CALL  = 3'd5,
        RET   = 3'd6,
        LUTWR = 3'd7
    } br_op_t;

    localparam int DEF_W           = 16;
    localparam int DEF_LUT_DEPTH   = 16;
    localparam int DEF_STACK_DEPTH = 4;

endpackage

// File: rtl/link_stack.sv
// Return-address stack: push/pop/top with full/empty and overflow/underflow pulses.
// Latency: top/full/empty reflect state registered at the last edge; pulses are same-cycle.
// Backpressure: none; a push when full or a pop when empty is dropped and flagged.
module link_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign wr_idx    = IW'(ptr);
    assign top_idx   = IW'(ptr - PW'(1));
    assign full      = (ptr == PW'(DEPTH));
    assign empty     = (ptr == '0);
    assign top       = empty ? '0 : mem[top_idx];
    assign overflow  = push && full;
    assign underflow = pop && empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            ptr         <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump decode for the PC: flags, writable target LUT, optional link stack (BRANCH_LINK_STACK_EN).
// Latency: zero-cycle decode to jump_rel/jump_abs/target; state updates at the op's rising edge.
// Backpressure: none; init stalls all state and suppresses jumps, reset overrides init.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int LUT_DEPTH   = DEF_LUT_DEPTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [W-1:0]                 pc,
    input  br_op_t                       br_op,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
    input  logic [W-1:0]                 lut_wdata,
    input  logic                         flag_we,
    input  logic                         zero_in,
    input  logic                         carry_in,
    output logic                         jump_rel,
    output logic                         jump_abs,
    output logic [W-1:0]                 target,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         err
);

    logic         z_q;
    logic         c_q;
    logic [W-1:0] lut [LUT_DEPTH];
    logic [W-1:0] lut_rd;
    logic         active;

    assign lut_rd = lut[lut_idx];
    assign active = !reset && !init;

`ifdef BRANCH_LINK_STACK_EN
    logic         push;
    logic         pop;
    logic [W-1:0] stk_top;
    logic         overflow;
    logic         underflow;
    logic         err_q;

    link_stack #(.W(W), .DEPTH(STACK_DEPTH)) u_link_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc + W'(1)),
        .top       (stk_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Overflow/underflow only pulse when the op is live, so err honours init.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_q | overflow | underflow;
    end

    assign err = err_q;
`else
    logic unused_ok;
    localparam int unused_depth = STACK_DEPTH;

    assign unused_ok   = &{1'b0, pc};
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign err         = 1'b0;
`endif

    always_comb begin
        jump_rel = 1'b0;
        jump_abs = 1'b0;
        target   = '0;
`ifdef BRANCH_LINK_STACK_EN
        push     = 1'b0;
        pop      = 1'b0;
`endif
        if (active) begin
            case (br_op)
                BZ:  if (z_q)  begin jump_rel = 1'b1; target = lut_rd; end
                BNZ: if (!z_q) begin jump_rel = 1'b1; target = lut_rd; end
                BC:  if (c_q)  begin jump_rel = 1'b1; target = lut_rd; end
                JMP: begin jump_abs = 1'b1; target = lut_rd; end
`ifdef BRANCH_LINK_STACK_EN
                CALL: begin
                    jump_abs = 1'b1;
                    target   = lut_rd;
                    push     = 1'b1;
                end
                RET: begin
                    pop = 1'b1;
                    if (!stack_empty) begin
                        jump_abs = 1'b1;
                        target   = stk_top;
                    end
                end
`else
                CALL: begin jump_abs = 1'b1; target = lut_rd; end
`endif
                default: ;
            endcase
        end
    end

    // Flags are sampled by this cycle's branch before the new values land.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else if (!init) begin
            if (flag_we) begin
                z_q <= zero_in;
                c_q <= carry_in;
            end
            if (br_op == LUTWR) lut[lut_idx] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; expectations adapt to BRANCH_LINK_STACK_EN.
`timescale 1ns/1ps
module tb_branch_ctrl;
    import branch_pkg::*;

`ifdef BRANCH_LINK_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [15:0]  pc;
    br_op_t       br_op;
    logic [3:0]   lut_idx;
    logic [15:0]  lut_wdata;
    logic         flag_we;
    logic         zero_in;
    logic         carry_in;
    logic         jump_rel;
    logic         jump_abs;
    logic [15:0]  target;
    logic         stack_full;
    logic         stack_empty;
    logic         err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .pc          (pc),
        .br_op       (br_op),
        .lut_idx     (lut_idx),
        .lut_wdata   (lut_wdata),
        .flag_we     (flag_we),
        .zero_in     (zero_in),
        .carry_in    (carry_in),
        .jump_rel    (jump_rel),
        .jump_abs    (jump_abs),
        .target      (target),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input br_op_t o, input logic [3:0] idx, input logic [15:0] p);
        br_op   = o;
        lut_idx = idx;
        pc      = p;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; pc = '0; br_op = NONE; lut_idx = '0;
        lut_wdata = '0; flag_we = 1'b0; zero_in = 1'b0; carry_in = 1'b0;

        // Outputs held quiet while reset is asserted, even with a JMP presented.
        op(JMP, 4'd0, 16'h0);
        tick();
        sample();
        check("rst_jabs", jump_abs, 0);
        check("rst_target", target, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_err", err, 0);
        tick();
        reset = 1'b0;

        op(BZ, 4'd3, 16'h0);
        sample();
        check("bz0_rel", jump_rel, 0);
        check("bz0_target", target, 0);
        check("bz0_empty", stack_empty, 1);
        tick();

        op(LUTWR, 4'd2, 16'h0); lut_wdata = 16'hFFFC; flag_we = 1'b1; zero_in = 1'b1;
        sample();
        check("lutwr_rel", jump_rel, 0);
        check("lutwr_abs", jump_abs, 0);
        check("lutwr_target", target, 0);
        tick();
        flag_we = 1'b0;

        op(BZ, 4'd2, 16'h0);
        sample();
        check("bz1_rel", jump_rel, 1);
        check("bz1_target", target, 16'hFFFC);
        tick();

        op(BNZ, 4'd2, 16'h0);
        sample();
        check("bnz_rel", jump_rel, 0);
        check("bnz_target", target, 0);
        tick();

        // Same-cycle flag write must not affect this branch.
        op(BZ, 4'd2, 16'h0); flag_we = 1'b1; zero_in = 1'b0;
        sample();
        check("bz_samecyc_rel", jump_rel, 1);
        check("bz_samecyc_target", target, 16'hFFFC);
        tick();
        flag_we = 1'b0;

        op(BZ, 4'd2, 16'h0);
        sample();
        check("bz_after_rel", jump_rel, 0);
        tick();

        op(BC, 4'd2, 16'h0);
        sample();
        check("bc_clear_rel", jump_rel, 0);
        op(NONE, 4'd0, 16'h0); flag_we = 1'b1; carry_in = 1'b1;
        tick();
        flag_we = 1'b0;
        op(BC, 4'd2, 16'h0);
        sample();
        check("bc_set_rel", jump_rel, 1);
        check("bc_set_abs", jump_abs, 0);
        check("bc_set_target", target, 16'hFFFC);
        tick();

        op(LUTWR, 4'd5, 16'h0); lut_wdata = 16'h0040;
        tick();
        op(CALL, 4'd5, 16'h0010);
        sample();
        check("call_abs", jump_abs, 1);
        check("call_rel", jump_rel, 0);
        check("call_target", target, 16'h0040);
        tick();
        op(RET, 4'd0, 16'h0040);
        sample();
        check("ret_empty_before", stack_empty, STK ? 0 : 1);
        check("ret_abs", jump_abs, STK ? 1 : 0);
        check("ret_target", target, STK ? 16'h0011 : 16'h0);
        tick();
        op(NONE, 4'd0, 16'h0);
        sample();
        check("ret_empty_after", stack_empty, 1);
        check("ret_err", err, 0);

        for (int i = 0; i < 5; i++) begin
            op(CALL, 4'd5, 16'h0100 + 16'(i));
            sample();
            check($sformatf("call%0d_abs", i), jump_abs, 1);
            check($sformatf("call%0d_target", i), target, 16'h0040);
            tick();
        end
        op(NONE, 4'd0, 16'h0);
        sample();
        check("ovf_full", stack_full, STK ? 1 : 0);
        check("ovf_err", err, STK ? 1 : 0);

        for (int i = 0; i < 5; i++) begin
            op(RET, 4'd0, 16'h0);
            sample();
            check($sformatf("ret%0d_abs", i), jump_abs, (STK && i < 4) ? 1 : 0);
            check($sformatf("ret%0d_target", i), target,
                  (STK && i < 4) ? 32'h0104 - 32'(i) : 32'h0);
            tick();
        end
        op(NONE, 4'd0, 16'h0);
        sample();
        check("ret_all_empty", stack_empty, 1);
        check("ret_all_err", err, STK ? 1 : 0);

        op(CALL, 4'd5, 16'h0200);
        tick();
        init = 1'b1;
        op(CALL, 4'd5, 16'h0300);
        sample();
        check("init_call_abs", jump_abs, 0);
        check("init_call_target", target, 0);
        tick();
        op(LUTWR, 4'd5, 16'h0); lut_wdata = 16'h1234;
        sample();
        check("init_lutwr_abs", jump_abs, 0);
        tick();
        init = 1'b0;
        op(JMP, 4'd5, 16'h0);
        sample();
        check("init_lut_kept", target, 16'h0040);
        check("init_empty", stack_empty, STK ? 0 : 1);
        tick();
        op(RET, 4'd0, 16'h0);
        sample();
        check("init_ret_target", target, STK ? 16'h0201 : 16'h0);
        tick();
        op(NONE, 4'd0, 16'h0);
        sample();
        check("init_ret_empty", stack_empty, 1);

        // Reset with a live stack entry discards it and clears err.
        op(CALL, 4'd5, 16'h0400);
        tick();
        reset = 1'b1; init = 1'b1;
        op(RET, 4'd0, 16'h0);
        sample();
        check("midrst_abs", jump_abs, 0);
        check("midrst_target", target, 0);
        tick();
        reset = 1'b0; init = 1'b0;
        op(NONE, 4'd0, 16'h0);
        sample();
        check("postrst_empty", stack_empty, 1);
        check("postrst_full", stack_full, 0);
        check("postrst_err", err, 0);
        op(JMP, 4'd5, 16'h0);
        sample();
        check("postrst_lut", target, 0);
        tick();
        op(RET, 4'd0, 16'h0);
        sample();
        check("postrst_ret_abs", jump_abs, 0);
        tick();
        op(NONE, 4'd0, 16'h0);
        sample();
        check("underflow_err", err, STK ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
